// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the two-requester data memory arbiter.
package data_mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_grant2.sv
// Combinational two-way grant: round-robin with bounded hold, or strict A priority.
module rr_grant2
    import data_mem_pkg::*;
#(
    parameter int FIXED_A  = 0,
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
    input  logic              req_a,
    input  logic              req_b,
    input  arb_state_t        owner,
    input  logic [HOLD_W-1:0] hold_cnt,
    input  logic              last_winner,
    output logic              grant_a,
    output logic              grant_b
);

    logic hold_ok;

    assign hold_ok = (hold_cnt < HOLD_W'(MAX_HOLD));

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (FIXED_A != 0) begin
            // Strict priority collapses every state to "A whenever it asks".
            grant_a = req_a;
            grant_b = req_b & ~req_a;
        end else begin
            case (owner)
                OWN_A: begin
                    if (req_a && (!req_b || hold_ok)) grant_a = 1'b1;
                    else                              grant_b = req_b;
                end
                OWN_B: begin
                    if (req_b && (!req_a || hold_ok)) grant_b = 1'b1;
                    else                              grant_a = req_a;
                end
                default: begin
                    if (req_a && req_b) begin
                        grant_a = (last_winner == REQ_B);
                        grant_b = (last_winner == REQ_A);
                    end else begin
                        grant_a = req_a;
                        grant_b = req_b;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one RAM port between requesters A and B; grants combinationally and
// steers the RAM's 1-cycle read data back to whichever requester issued the read.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FIXED_A  = 0,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_byteenable,
    input  logic                a_read,
    input  logic                a_write,
    input  logic [DATA_W-1:0]   a_writedata,
    output logic                a_waitrequest,
    output logic [DATA_W-1:0]   a_readdata,
    output logic                a_readdatavalid,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W/8-1:0] b_byteenable,
    input  logic                b_read,
    input  logic                b_write,
    input  logic [DATA_W-1:0]   b_writedata,
    output logic                b_waitrequest,
    output logic [DATA_W-1:0]   b_readdata,
    output logic                b_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam int BE_W   = DATA_W / 8;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    arb_state_t        state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              last_winner;
    logic              rd_pend_a, rd_pend_b;
    logic              req_a, req_b;
    logic              grant_raw_a, grant_raw_b, grant_a, grant_b;
    logic [ADDR_W-1:0] addr_hold;
    logic [BE_W-1:0]   be_hold;
    logic [DATA_W-1:0] wdata_hold;

    assign req_a = a_read | a_write;
    assign req_b = b_read | b_write;

    rr_grant2 #(
        .FIXED_A  (FIXED_A),
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) u_grant (
        .req_a       (req_a),
        .req_b       (req_b),
        .owner       (state),
        .hold_cnt    (hold_cnt),
        .last_winner (last_winner),
        .grant_a     (grant_raw_a),
        .grant_b     (grant_raw_b)
    );

    // No request may be accepted while reset is held.
    assign grant_a = grant_raw_a & reset_n;
    assign grant_b = grant_raw_b & reset_n;

    always_comb begin
        state_nxt      = IDLE;
        mem_address    = addr_hold;
        mem_byteenable = be_hold;
        mem_writedata  = wdata_hold;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (grant_a) begin
            state_nxt      = OWN_A;
            mem_address    = a_address;
            mem_byteenable = a_byteenable;
            mem_writedata  = a_writedata;
            mem_chipselect = 1'b1;
            mem_write      = a_write;
        end else if (grant_b) begin
            state_nxt      = OWN_B;
            mem_address    = b_address;
            mem_byteenable = b_byteenable;
            mem_writedata  = b_writedata;
            mem_chipselect = 1'b1;
            mem_write      = b_write;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            last_winner <= REQ_B;
            rd_pend_a   <= 1'b0;
            rd_pend_b   <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_pend_a <= grant_a & a_read & ~a_write;
            rd_pend_b <= grant_b & b_read & ~b_write;
            if (grant_a | grant_b) begin
                last_winner <= grant_b ? REQ_B : REQ_A;
                if (state_nxt != state)
                    hold_cnt <= HOLD_W'(1);
                else if (hold_cnt != HOLD_W'(MAX_HOLD))
                    hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end

    // Idle cycles replay the last granted address/data so the RAM inputs stay quiet.
    always_ff @(posedge clk) begin
        if (grant_a | grant_b) begin
            addr_hold  <= mem_address;
            be_hold    <= mem_byteenable;
            wdata_hold <= mem_writedata;
        end
    end

    assign a_waitrequest   = ~reset_n | (req_a & ~grant_a);
    assign b_waitrequest   = ~reset_n | (req_b & ~grant_b);
    assign a_readdata      = mem_readdata;
    assign b_readdata      = mem_readdata;
    assign a_readdatavalid = rd_pend_a;
    assign b_readdatavalid = rd_pend_b;
    assign mem_clken       = reset_n;

endmodule
